// File: rtl/clz_decode_if.sv
// Purpose : request/result bundle between the EX-stage pipeline and clz_decode.
// Ports   : master drives start/flush/cnt_in/norm_in; slave returns busy/done/err/res/mask.
// Notes   : WIDTH is carried here so both ends agree on operand width (only 32 is supported).
interface clz_decode_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             flush;
  logic [5:0]       cnt_in;
  logic [WIDTH-1:0] norm_in;
  logic             busy;
  logic             done;
  logic             err;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] mask;

  modport master (
    output start, flush, cnt_in, norm_in,
    input  busy, done, err, res, mask
  );

  modport slave (
    input  start, flush, cnt_in, norm_in,
    output busy, done, err, res, mask
  );
endinterface

// File: rtl/clz_decode.sv
// Purpose : rebuilds a 32-bit value from (normalized operand, leading-zero count) by
//           shifting right one bit per cycle; also emits the leading-one mask and an error flag.
// Latency : done in the cycle after E0 for n=0, n=32 or error; after En for n=1..31.
// Backpr. : no queueing; start is only sampled in IDLE, busy stalls the pipeline, flush aborts.
// Ports   : clk, rst_n (async active-low); bus (slave): start, flush, cnt_in, norm_in in;
//           busy, done, err, res, mask out. All outputs come straight from registers.
module clz_decode #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  clz_decode_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_mask;
  logic [5:0]       r_rem;
  logic             r_err;

  logic             w_accept;
  logic             w_req_err;
  logic             w_cnt_zero;
  logic             w_cnt_max;
  logic [WIDTH-1:0] w_mask_new;

  // Flush wins over start, so a flushed start never loads the result registers.
  assign w_accept   = (r_state == S_IDLE) && bus.start && !bus.flush;
  assign w_cnt_zero = (bus.cnt_in == 6'd0);
  assign w_cnt_max  = (bus.cnt_in == 6'd32);

  // A count/operand pair is inconsistent when the count is out of range, when a
  // non-full count comes with an operand that is not normalized, or when a full
  // count (value was zero) comes with a non-zero operand.
  assign w_req_err = (bus.cnt_in > 6'd32)
                  || ((bus.cnt_in <= 6'd31) && !bus.norm_in[WIDTH-1])
                  || (w_cnt_max && (bus.norm_in != '0));

  // Leading one of the rebuilt value sits at bit (31-n); only used for n <= 31.
  assign w_mask_new = {1'b1, {(WIDTH-1){1'b0}}} >> bus.cnt_in[4:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          if (w_req_err || w_cnt_max || w_cnt_zero) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        if (r_rem == 6'd1) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (bus.flush) begin
      w_state_nxt = S_IDLE;
    end
  end

  // Result registers: loaded on accept, shifted in SHIFT, otherwise held
  // (including across a flush, which leaves partial contents in place).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res  <= '0;
      r_mask <= '0;
      r_rem  <= 6'd0;
      r_err  <= 1'b0;
    end else if (w_accept) begin
      r_err <= w_req_err;
      if (w_req_err || w_cnt_max) begin
        r_res  <= '0;
        r_mask <= '0;
        r_rem  <= 6'd0;
      end else begin
        r_res  <= bus.norm_in;
        r_mask <= w_mask_new;
        r_rem  <= bus.cnt_in;
      end
    end else if ((r_state == S_SHIFT) && !bus.flush) begin
      r_res <= {1'b0, r_res[WIDTH-1:1]};
      r_rem <= r_rem - 6'd1;
    end
  end

  assign bus.busy = (r_state != S_IDLE);
  assign bus.done = (r_state == S_DONE);
  assign bus.err  = r_err;
  assign bus.res  = r_res;
  assign bus.mask = r_mask;

endmodule

// File: tb/tb_clz_decode.sv
// Purpose : self-checking bench for clz_decode using an expected-result scoreboard.
// Latency : expected busy-cycle count at done is n+1 for n=1..31, else 1.
// Backpr. : requests are issued only when the DUT is idle; mid-busy starts must be ignored.
module tb_clz_decode;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  clz_decode_if #(.WIDTH(32)) bus ();

  clz_decode #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [31:0] mask;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_err = 0;
  int   bcnt  = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Reference: the rebuilt value is simply the operand shifted right by n.
  function automatic exp_t model(input logic [5:0] cnt, input logic [31:0] norm);
    exp_t e;
    e.err = (cnt > 6'd32) || ((cnt < 6'd32) && !norm[31]) || ((cnt == 6'd32) && (norm != 32'h0));
    if (e.err || (cnt == 6'd32)) begin
      e.res  = 32'h0;
      e.mask = 32'h0;
      e.lat  = 1;
    end else begin
      e.res  = norm >> cnt;
      e.mask = 32'h1 << (31 - int'(cnt));
      e.lat  = (cnt == 6'd0) ? 1 : int'(cnt) + 1;
    end
    return e;
  endfunction

  // Monitor: counts busy cycles of the current request and scores each done.
  always @(negedge clk) begin
    if (bus.busy) bcnt++;
    else bcnt = 0;
    if (bus.done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'(bus.done), 32'h0);
      end else begin
        mon_e = sb.pop_front();
        check("res",  bus.res,  mon_e.res);
        check("mask", bus.mask, mon_e.mask);
        check("err",  32'(bus.err), 32'(mon_e.err));
        check("latency", 32'(bcnt), 32'(mon_e.lat));
        check("busy_with_done", 32'(bus.busy), 32'h1);
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!bus.busy && (sb.size() == 0)) break;
    end
    check("idle_timeout", 32'(bus.busy), 32'h0);
  endtask

  // Called at a negedge while idle; the following posedge is the accept edge E0.
  task automatic issue(input logic [5:0] cnt, input logic [31:0] norm, input bit track);
    bus.cnt_in  = cnt;
    bus.norm_in = norm;
    bus.start   = 1'b1;
    if (track) sb.push_back(model(cnt, norm));
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic run_chk(input logic [5:0] cnt, input logic [31:0] norm,
                         input logic [31:0] eres, input logic [31:0] emask, input logic eerr);
    wait_idle();
    issue(cnt, norm, 1'b1);
    wait_idle();
    // Values must still be held in the idle cycle after done.
    check("tp_res",  bus.res,  eres);
    check("tp_mask", bus.mask, emask);
    check("tp_err",  32'(bus.err), 32'(eerr));
  endtask

  initial begin
    logic [5:0]  rc;
    logic [31:0] rn;
    bus.start   = 1'b0;
    bus.flush   = 1'b0;
    bus.cnt_in  = 6'd0;
    bus.norm_in = 32'h0;

    #12;
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_done", 32'(bus.done), 32'h0);
    check("rst_err",  32'(bus.err),  32'h0);
    check("rst_res",  bus.res,  32'h0);
    check("rst_mask", bus.mask, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_chk(6'd31, 32'h8000_0000, 32'h0000_0001, 32'h0000_0001, 1'b0);
    run_chk(6'd4,  32'hF000_0000, 32'h0F00_0000, 32'h0800_0000, 1'b0);
    run_chk(6'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h8000_0000, 1'b0);
    run_chk(6'd32, 32'h0000_0000, 32'h0,         32'h0,         1'b0);
    run_chk(6'd33, 32'h1234_5678, 32'h0,         32'h0,         1'b1);
    run_chk(6'd5,  32'h4000_0000, 32'h0,         32'h0,         1'b1);
    run_chk(6'd32, 32'h0000_0001, 32'h0,         32'h0,         1'b1);
    run_chk(6'd31, 32'h0000_0000, 32'h0,         32'h0,         1'b1);

    // start pulsed while shifting must be ignored
    wait_idle();
    issue(6'd4, 32'hF000_0000, 1'b1);
    @(negedge clk);
    bus.cnt_in  = 6'd0;
    bus.norm_in = 32'hDEAD_BEEF;
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle();
    check("ignored_start_res", bus.res, 32'h0F00_0000);

    // flush at E5 of a 20-shift request; the next request goes in straight after
    wait_idle();
    issue(6'd20, 32'h8000_0000, 1'b0);
    repeat (4) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush_busy", 32'(bus.busy), 32'h0);
    check("flush_done", 32'(bus.done), 32'h0);
    check("flush_res_held", bus.res, 32'h0800_0000);
    issue(6'd4, 32'hF000_0000, 1'b1);
    check("accept_after_flush", 32'(bus.busy), 32'h1);
    wait_idle();

    // flush beats start in IDLE
    bus.flush = 1'b1;
    issue(6'd3, 32'h8000_0000, 1'b0);
    bus.flush = 1'b0;
    check("flush_prio_busy", 32'(bus.busy), 32'h0);

    // asynchronous reset in the middle of SHIFT
    wait_idle();
    issue(6'd31, 32'h8000_0000, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(bus.busy), 32'h0);
    check("arst_done", 32'(bus.done), 32'h0);
    check("arst_err",  32'(bus.err),  32'h0);
    check("arst_res",  bus.res,  32'h0);
    check("arst_mask", bus.mask, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run_chk(6'd1, 32'h8000_0000, 32'h4000_0000, 32'h4000_0000, 1'b0);

    // random legal requests issued back-to-back
    for (int k = 0; k < 8; k++) begin
      rc = 6'($urandom_range(0, 32));
      rn = $urandom | 32'h8000_0000;
      if (rc == 6'd32) rn = 32'h0;
      wait_idle();
      issue(rc, rn, 1'b1);
    end
    wait_idle();
    check("scoreboard_empty", 32'(sb.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/clz_decode.md
# clz_decode

Multi-cycle inverse of the execute-stage count-leading-zeros unit. It takes a normalized operand (MSB set) and a leading-zero count, and shifts the operand right one bit per cycle to rebuild the original 32-bit value. It also produces a one-hot mask of the leading-one position and flags inconsistent count/operand pairs. It sits beside the EX-stage ALU and stalls the pipeline through `busy`, using a start/done handshake.

## Interface
- `WIDTH`, 32: operand width. Only 32 is supported.
- `clk` in 1: clock. All state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: request. Sampled only in IDLE.
- `flush` in 1: synchronous abort from pipeline flush.
- `cnt_in` in 6: leading-zero count, legal range 0..32.
- `norm_in` in 32: normalized operand.
- `busy` out 1: high whenever state is not IDLE.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: inconsistent request. Valid with `done` and held afterwards.
- `res` out 32: reconstructed value.
- `mask` out 32: one-hot bit (31-n) for n ≤ 31; zero otherwise.

## Operation
- States: IDLE, SHIFT, DONE. Registers: 32-bit shift reg (drives `res`), 6-bit remaining count `rem`, `mask`, `err`.
- IDLE with `start`=1 (accept edge E0):
  - Capture the error condition as `err`. Error when:
    - `cnt_in` > 32, or
    - `cnt_in` ≤ 31 and `norm_in[31]`=0, or
    - `cnt_in` = 32 and `norm_in` ≠ 0.
  - If `err`: `res`=0, `mask`=0, next DONE.
  - Else if `cnt_in` = 32: `res`=0, `mask`=0, next DONE.
  - Else if `cnt_in` = 0: `res`=`norm_in`, `mask`=32'h8000_0000, next DONE.
  - Else: `res`=`norm_in`, `rem`=`cnt_in`, `mask`=1<<(31-`cnt_in`), next SHIFT.
- SHIFT, each edge:
  - `res` <= {1'b0, `res`[31:1]} (logical shift), `rem` <= `rem`-1.
  - When `rem` = 1 before the edge, next DONE.
- DONE: `done`=1 for exactly one cycle, then IDLE on the next edge.
- `start` in SHIFT or DONE is ignored. No queueing.
- `res`, `mask`, `err` hold their values after `done` until the next accepted `start` or reset.
- `flush`=1 at any edge (SHIFT, DONE, or IDLE with `start`) forces IDLE. It has priority over `start`.
  - No `done` pulse is produced.
  - `res`/`mask`/`err` keep their current contents; they are undefined-as-result but are not cleared.
- Arithmetic: `rem` is 6-bit unsigned and never wraps, because SHIFT is entered only with 1..31.

## Timing
- Reset (async, `rst_n`=0): state IDLE; `busy`=0, `done`=0, `err`=0, `res`=0, `mask`=0, `rem`=0. Takes effect immediately, mid-operation included. The first accept is possible on the first edge after `rst_n` rises.
- Latency, with accept at E0 and n = `cnt_in`:
  - n = 1..31: shifts at E1..En. `done` is high in the cycle after En.
  - n = 0, n = 32, or error: `done` is high in the cycle after E0.
- `busy` rises in the cycle after E0 and falls in the cycle after `done`. `busy` and `done` overlap.
- Back-to-back: a new `start` is accepted at the edge that leaves DONE's following IDLE cycle. Minimum request spacing is latency+2 edges.
- Outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- `norm_in`=32'h8000_0000, `cnt_in`=31 → `done` after 31 shifts. `res`=32'h0000_0001, `mask`=32'h0000_0001, `err`=0, `busy` high for 32 cycles.
- `norm_in`=32'hF000_0000, `cnt_in`=4 → `done` in the cycle after E4. `res`=32'h0F00_0000, `mask`=32'h0800_0000.
- `cnt_in`=0, `norm_in`=32'hDEAD_BEEF → `done` the cycle after E0, `res`=32'hDEAD_BEEF; `cnt_in`=32, `norm_in`=0 → `res`=0, `mask`=0, `err`=0.
- Errors:
  - `cnt_in`=33 → `err`=1, `res`=0.
  - `cnt_in`=5 with `norm_in`=32'h4000_0000 → `err`=1, `res`=0, `mask`=0, single-cycle `done`.
- Start with `cnt_in`=20, then:
  - assert `flush` at E5 → IDLE, `busy`=0, no `done`; a new request is accepted next cycle.
  - `start` pulsed while busy is ignored.
- Drop `rst_n` during SHIFT → all outputs 0 immediately. After release, a request `cnt_in`=1, `norm_in`=32'h8000_0000 → `res`=32'h4000_0000.
